// File: rtl/duck_pkg.sv
// Shared definitions for the duck sprite reader: sprite geometry defaults, ROM address width
// and the VGA timing bundle that travels down the pixel pipeline.
package duck_pkg;

    localparam int          DUCK_W_DEF          = 96;
    localparam int          DUCK_H_DEF          = 60;
    localparam int          DUCK_ROM_AW         = 13;
    localparam logic [11:0] TRANSPARENT_RGB_DEF = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_timing_t;

endpackage

// File: rtl/draw_duck_delay.sv
// STAGES-deep register chain for the VGA timing bundle and the background pixel,
// cleared by the synchronous active-high reset.
module draw_duck_delay
    import duck_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  vga_timing_t tim_i,
    input  logic [11:0] rgb_i,
    output vga_timing_t tim_o,
    output logic [11:0] rgb_o
);

    vga_timing_t tim_q [STAGES];
    logic [11:0] rgb_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                tim_q[i] <= '0;
                rgb_q[i] <= '0;
            end
        end else begin
            tim_q[0] <= tim_i;
            rgb_q[0] <= rgb_i;
            for (int i = 1; i < STAGES; i++) begin
                tim_q[i] <= tim_q[i-1];
                rgb_q[i] <= rgb_q[i-1];
            end
        end
    end

    assign tim_o = tim_q[STAGES-1];
    assign rgb_o = rgb_q[STAGES-1];

endmodule

// File: rtl/draw_duck.sv
// Duck sprite overlay: issues addresses to an external synchronous duck ROM and composites
// its pixels over the background with a transparent key colour. Define DUCK_FLIP_EN for mirroring.
module draw_duck
    import duck_pkg::*;
#(
    parameter int          DUCK_W          = DUCK_W_DEF,
    parameter int          DUCK_H          = DUCK_H_DEF,
    parameter logic [11:0] TRANSPARENT_RGB = TRANSPARENT_RGB_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [10:0]            hcount_in,
    input  logic [10:0]            vcount_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   hblnk_in,
    input  logic                   vblnk_in,
    input  logic [11:0]            rgb_in,
    input  logic [10:0]            xpos,
    input  logic [10:0]            ypos,
`ifdef DUCK_FLIP_EN
    input  logic                   flip,
`endif
    output logic [DUCK_ROM_AW-1:0] rom_addr,
    input  logic [11:0]            rom_rgb,
    output logic [10:0]            hcount_out,
    output logic [10:0]            vcount_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   hblnk_out,
    output logic                   vblnk_out,
    output logic [11:0]            rgb_out
);

    function automatic logic [11:0] composite(input logic        blank,
                                              input logic        in_spr,
                                              input logic [11:0] spr_rgb,
                                              input logic [11:0] bg_rgb);
        if (blank)
            return 12'h000;
        else if (in_spr && (spr_rgb != TRANSPARENT_RGB))
            return spr_rgb;
        else
            return bg_rgb;
    endfunction

    logic [10:0]            xpos_l_q, xpos_l_d;
    logic [10:0]            ypos_l_q, ypos_l_d;
    logic                   frame_start;
    logic [11:0]            h_ext, v_ext, x_lo, y_lo, x_hi, y_hi;
    logic [10:0]            dx, dy, col;
    logic                   in_spr_p0;
    logic [DUCK_ROM_AW-1:0] addr_p0;
    logic [DUCK_ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic                   in_spr_p1_q, in_spr_p2_q;
    vga_timing_t            tim_p0, tim_p2;
    logic [11:0]            rgb_p2;

    // Position is only taken at frame start so a moving duck never tears mid-frame.
    assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

    always_comb begin
        xpos_l_d = xpos_l_q;
        ypos_l_d = ypos_l_q;
        if (frame_start) begin
            xpos_l_d = xpos;
            ypos_l_d = ypos;
        end
    end

`ifdef DUCK_FLIP_EN
    logic flip_l_q, flip_l_d;

    always_comb begin
        flip_l_d = flip_l_q;
        if (frame_start)
            flip_l_d = flip;
    end

    always_ff @(posedge clk) begin
        if (rst)
            flip_l_q <= 1'b0;
        else
            flip_l_q <= flip_l_d;
    end

    assign col = flip_l_q ? (11'(DUCK_W - 1) - dx) : dx;
`else
    assign col = dx;
`endif

    // Stage p0 -> p1: hit test in 12 bits so xpos_l + DUCK_W cannot wrap past 2047.
    assign h_ext = {1'b0, hcount_in};
    assign v_ext = {1'b0, vcount_in};
    assign x_lo  = {1'b0, xpos_l_q};
    assign y_lo  = {1'b0, ypos_l_q};
    assign x_hi  = x_lo + 12'(DUCK_W);
    assign y_hi  = y_lo + 12'(DUCK_H);

    assign in_spr_p0 = (h_ext >= x_lo) && (h_ext < x_hi) &&
                       (v_ext >= y_lo) && (v_ext < y_hi) &&
                       !hblnk_in && !vblnk_in;

    assign dx = hcount_in - xpos_l_q;
    assign dy = vcount_in - ypos_l_q;

    assign addr_p0    = DUCK_ROM_AW'(dy) * DUCK_ROM_AW'(DUCK_W) + DUCK_ROM_AW'(col);
    assign rom_addr_d = in_spr_p0 ? addr_p0 : rom_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_l_q    <= '0;
            ypos_l_q    <= '0;
            rom_addr_q  <= '0;
            in_spr_p1_q <= 1'b0;
            in_spr_p2_q <= 1'b0;
        end else begin
            xpos_l_q    <= xpos_l_d;
            ypos_l_q    <= ypos_l_d;
            rom_addr_q  <= rom_addr_d;
            in_spr_p1_q <= in_spr_p0;
            in_spr_p2_q <= in_spr_p1_q;
        end
    end

    assign rom_addr = rom_addr_q;

    always_comb begin
        tim_p0        = '0;
        tim_p0.hcount = hcount_in;
        tim_p0.vcount = vcount_in;
        tim_p0.hsync  = hsync_in;
        tim_p0.vsync  = vsync_in;
        tim_p0.hblnk  = hblnk_in;
        tim_p0.vblnk  = vblnk_in;
    end

    draw_duck_delay #(
        .STAGES (2)
    ) u_delay (
        .clk   (clk),
        .rst   (rst),
        .tim_i (tim_p0),
        .rgb_i (rgb_in),
        .tim_o (tim_p2),
        .rgb_o (rgb_p2)
    );

    // Stage p2: rom_rgb is the synchronous ROM's answer to the address registered at p1.
    assign rgb_out    = composite(tim_p2.hblnk || tim_p2.vblnk, in_spr_p2_q, rom_rgb, rgb_p2);
    assign hcount_out = tim_p2.hcount;
    assign vcount_out = tim_p2.vcount;
    assign hsync_out  = tim_p2.hsync;
    assign vsync_out  = tim_p2.vsync;
    assign hblnk_out  = tim_p2.hblnk;
    assign vblnk_out  = tim_p2.vblnk;

endmodule

// File: doc/draw_duck.md
Name: draw_duck

Overview:
- Sprite reader on the pixel pipeline; the requesting end of the 96x60 duck image ROM (13-bit address in, 12-bit rgb out one clock later).
- Compares the incoming VGA timing against the duck position and issues a ROM address for each covered pixel.
- Overlays the returned pixel on the background, treating a key colour as transparent, and forwards the timing with matching delay.
- Sits between the background drawer and the crosshair/mouse drawer.

Parameters:
- DUCK_W, 96, sprite width in pixels
- DUCK_H, 60, sprite height in pixels
- TRANSPARENT_RGB, 12'hF0F, ROM colour that passes the background through

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes
- rgb_in  in  12  background pixel
- xpos  in  11  sprite left column, may change at any time
- ypos  in  11  sprite top line, may change at any time
- rom_addr  out  13  address to duck ROM, {y*96 + x}
- rom_rgb  in  12  ROM data, valid 1 clk after rom_addr
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed strobes
- rgb_out  out  12  composited pixel

Behaviour:
- Reset: all outputs 0, including rom_addr and all pipeline registers. The latched position is also 0.
- Position latch:
  - xpos/ypos are sampled into xpos_l/ypos_l only on the cycle where hcount_in==0 and vcount_in==0.
  - Motion mid-frame is invisible until the next frame, so there is no tearing.
  - Reset mid-frame holds position 0 until the next frame start.
- Stage 1 (cycle N+1):
  - dx = hcount_in - xpos_l and dy = vcount_in - ypos_l, both 11-bit unsigned.
  - in_spr = (hcount_in >= xpos_l) && (hcount_in < xpos_l + DUCK_W) && same for v/H; bounds are computed 12-bit to avoid overflow.
  - Blanking inside the sprite area forces in_spr=0.
  - rom_addr is registered as (dy<<6)+(dy<<5)+dx[6:0] when in_spr, else it holds its previous value.
  - Maximum address is 5759; rom_addr never exceeds 5759.
- Stage 2 (cycle N+2):
  - rgb_out = rom_rgb if in_spr_d && rom_rgb != TRANSPARENT_RGB, else the delayed rgb_in.
  - Blanked pixels output 12'h000.
- Latency: exactly 2 clk for every output relative to its input, with all timing fields delayed identically.
- Edges:
  - A sprite partially off-screen (xpos > 1024-96) draws only the visible part; no wrap to column 0.
  - xpos_l + DUCK_W > 2047 is handled by the 12-bit compare; no aliasing.
  - The first pixel (dx=0,dy=0) and the last pixel (dx=95,dy=59) are both drawn; dx=96 and dy=60 are not.

Optional Feature:
- Macro DUCK_FLIP_EN.
- Defined:
  - Adds input port flip (1 bit), latched together with the position.
  - When the latched flip=1, the column becomes (DUCK_W-1)-dx, mirroring the duck horizontally.
  - Latency is unchanged.
- Undefined: no flip port; the address always uses dx.

Decomposition:
- Package duck_pkg:
  - DUCK_W/DUCK_H defaults, DUCK_ROM_AW=13, TRANSPARENT_RGB default.
  - A typedef struct for the VGA timing bundle (hcount, vcount, hsync, vsync, hblnk, vblnk).
- Sub-module draw_duck_delay: a parameterised N-stage register for the timing bundle and background rgb, with synchronous reset.
- The duck ROM is instantiated by the parent, not inside draw_duck.

Test Plan:
- Reset asserted for 3 clk mid-line -> all outputs 0 during reset; first post-reset outputs equal the inputs from 2 clk earlier.
- xpos=100, ypos=50 latched, hcount=100, vcount=50 -> rom_addr=0. Then hcount=195, vcount=109 -> rom_addr=5759; rgb_out equals rom_rgb 2 clk after each input.
- hcount=196 or vcount=110 with the same position -> rgb_out equals the delayed rgb_in; rom_addr is unchanged.
- ROM model returns 12'hF0F inside the sprite -> rgb_out equals the delayed background; returns 12'h8A2 -> rgb_out=12'h8A2.
- xpos changes from 100 to 300 at line 200 -> the rest of the frame still draws at 100; the next frame draws at 300.
- With DUCK_FLIP_EN, flip=1, hcount=xpos_l, vcount=ypos_l -> rom_addr=95. Edge case xpos=1000, hcount=1023 -> rom_addr=23; no wrap pixels at hcount 0..71.
